// File: rtl/mem_ctrl_4k_if.sv
// Requester-side bus of the 4K x 16 RAM controller: request and response handshakes.
// Optional MEMCTL_BURST_EN adds req_len (read burst length minus 1).
interface mem_ctrl_4k_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
`ifdef MEMCTL_BURST_EN
  logic [2:0]  req_len;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;

`ifdef MEMCTL_BURST_EN
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif
endinterface

// File: rtl/mem_ctrl_4k.sv
// Single-port 4K x 16 RAM controller: IDLE -> WRITE/READ -> RESP, all outputs registered.
// Ports: clk, rst_n (async low), bus (slave), ram_e/w/r/addr/din out, ram_dout in.
// MEMCTL_BURST_EN: reads of req_len+1 beats at wrapping consecutive addresses.
module mem_ctrl_4k (
  input  logic         clk,
  input  logic         rst_n,
  mem_ctrl_4k_if.slave bus,
  output logic         ram_e,
  output logic         ram_w,
  output logic         ram_r,
  output logic [11:0]  ram_addr,
  output logic [15:0]  ram_din,
  input  logic [15:0]  ram_dout
);

  typedef enum logic [1:0] {
    IDLE, WRITE, READ, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        vld_q, vld_d;
  logic [15:0] rdata_q, rdata_d;
  logic        e_q, e_d;
  logic        w_q, w_d;
  logic        r_q, r_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        acc, done, last;

`ifdef MEMCTL_BURST_EN
  logic [2:0]  cnt_q, cnt_d;
  assign last = (cnt_q == 3'd0);
`else
  assign last = 1'b1;
`endif

  assign acc  = (state_q == IDLE) && rdy_q && bus.req_valid;
  assign done = (state_q == RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      e_q     <= 1'b0;
      w_q     <= 1'b0;
      r_q     <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef MEMCTL_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      e_q     <= e_d;
      w_q     <= w_d;
      r_q     <= r_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef MEMCTL_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (acc) state_d = bus.req_we ? WRITE : READ;
      WRITE: state_d = RESP;
      READ:  state_d = RESP;
      RESP:  if (done) state_d = last ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered.
  always_comb begin
    rdy_d   = (state_d == IDLE);
    vld_d   = (state_d == RESP);
    e_d     = (state_d == WRITE) || (state_d == READ);
    w_d     = (state_d == WRITE);
    r_d     = (state_d == READ);
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
`ifdef MEMCTL_BURST_EN
    cnt_d   = cnt_q;
`endif
    if (acc) begin
      addr_d = bus.req_addr;
      din_d  = bus.req_wdata;
`ifdef MEMCTL_BURST_EN
      cnt_d  = bus.req_we ? 3'd0 : bus.req_len;
`endif
    end
    if (state_q == WRITE) rdata_d = '0;
    if (state_q == READ)  rdata_d = ram_dout;
`ifdef MEMCTL_BURST_EN
    // Next beat: 12-bit add wraps FFF -> 000.
    if (done && !last) begin
      addr_d = addr_q + 12'd1;
      cnt_d  = cnt_q - 3'd1;
    end
`endif
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign ram_e         = e_q;
  assign ram_w         = w_q;
  assign ram_r         = r_q;
  assign ram_addr      = addr_q;
  assign ram_din       = din_q;

endmodule

// File: tb/tb_mem_ctrl_4k.sv
// Bench for mem_ctrl_4k: RAM model, scoreboard of expected read data, protocol monitor.
// Define MEMCTL_BURST_EN to also exercise burst reads.
module tb_mem_ctrl_4k;

  logic        clk;
  logic        rst_n;
  logic        ram_e, ram_w, ram_r;
  logic [11:0] ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic        init;
  logic        mon_en;

  logic [15:0] mem     [4096];
  logic [15:0] exp_mem [4096];
  logic [15:0] sbq[$];

  int n_cmp;
  int n_bad;

  mem_ctrl_4k_if bus ();

  mem_ctrl_4k dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .ram_e    (ram_e),
    .ram_w    (ram_w),
    .ram_r    (ram_r),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 37) ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (ram_e && ram_w) begin
      mem[ram_addr] <= ram_din;
    end
  end

  assign ram_dout = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("w_r_exclusive", 32'(ram_w & ram_r), 0);
      if (bus.req_ready || bus.rsp_valid)
        check("ram_e_idle_resp", 32'(ram_e), 0);
    end
  end

  task automatic xact(input logic we, input logic [11:0] a,
                      input logic [15:0] d, input logic [2:0] len,
                      input int hold);
    int beats;
    int k;
    logic [11:0] idx;
    logic [15:0] held;
    logic [15:0] e;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef MEMCTL_BURST_EN
    bus.req_len   = len;
    beats = we ? 1 : int'(len) + 1;
`else
    beats = (len == 3'd0 || len != 3'd0) ? 1 : 1;
`endif
    for (int b = 0; b < beats; b++) begin
      idx = a + 12'(b);
      sbq.push_back(we ? 16'h0000 : exp_mem[idx]);
    end
    if (we) exp_mem[a] = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ready_low_after_accept", 32'(bus.req_ready), 0);
    check("rsp_not_early", 32'(bus.rsp_valid), 0);
    check("ram_e_active", 32'(ram_e), 1);
    check("ram_w_strobe", 32'(ram_w), 32'(we));
    check("ram_r_strobe", 32'(ram_r), 32'(!we));
    check("ram_addr", 32'(ram_addr), 32'(a));
    if (we) check("ram_din", 32'(ram_din), 32'(d));
    for (int b = 0; b < beats; b++) begin
      if (b > 0) begin
        idx = a + 12'(b);
        check("burst_addr", 32'(ram_addr), 32'(idx));
        check("burst_ram_r", 32'(ram_r), 1);
        check("burst_rsp_low", 32'(bus.rsp_valid), 0);
      end
      @(negedge clk);
      check("rsp_valid_latency", 32'(bus.rsp_valid), 1);
      check("ready_low_in_resp", 32'(bus.req_ready), 0);
      held = bus.rsp_rdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("stall_rsp_valid", 32'(bus.rsp_valid), 1);
        check("stall_rdata", 32'(bus.rsp_rdata), 32'(held));
        check("stall_ready_low", 32'(bus.req_ready), 0);
      end
      check("sb_nonempty", 32'(sbq.size() != 0), 1);
      e = (sbq.size() != 0) ? sbq.pop_front() : 16'hxxxx;
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
    end
    check("idle_after_resp", 32'(bus.req_ready), 1);
    check("rsp_valid_cleared", 32'(bus.rsp_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    check({tag, "_ram_e"}, 32'(ram_e), 0);
    check({tag, "_ram_w"}, 32'(ram_w), 0);
    check({tag, "_ram_r"}, 32'(ram_r), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_din"}, 32'(ram_din), 0);
  endtask

  initial begin
    logic        we;
    logic [11:0] a;
    n_cmp  = 0;
    n_bad  = 0;
    mon_en = 1'b0;
    init   = 1'b1;
    rst_n  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef MEMCTL_BURST_EN
    bus.req_len   = '0;
`endif
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i);

    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    check("ready_low_at_release", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("ready_after_release", 32'(bus.req_ready), 1);

    xact(1'b1, 12'h123, 16'hBEEF, 3'd0, 0);
    xact(1'b0, 12'h123, 16'h0000, 3'd0, 0);
    xact(1'b0, 12'h123, 16'h0000, 3'd0, 5);
    xact(1'b0, 12'h456, 16'h0000, 3'd0, 0);

    xact(1'b1, 12'h010, 16'h0001, 3'd0, 0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 12'h010;
    bus.req_wdata = 16'h5555;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    check("abort_in_write", 32'(ram_w), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_low_after_abort", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("ready_after_abort", 32'(bus.req_ready), 1);
    xact(1'b0, 12'h010, 16'h0000, 3'd0, 0);

`ifdef MEMCTL_BURST_EN
    xact(1'b0, 12'hFFE, 16'h0000, 3'd3, 1);
    xact(1'b1, 12'h200, 16'h1234, 3'd5, 0);
    xact(1'b0, 12'h1FF, 16'h0000, 3'd2, 0);
`endif

    for (int t = 0; t < 24; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 12'h100 + 12'($urandom_range(0, 7));
      xact(we, a, 16'($urandom), 3'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)));
    end

    check("sb_drained", 32'(sbq.size()), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_4k.md
MEM_CTRL_4K -- requirements
Module: mem_ctrl_4k

Interface
REQ-001 SHALL have clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have req_valid, input, 1, requester presents a transaction.
REQ-004 SHALL have req_ready, output, 1, controller can accept a request.
REQ-005 SHALL have req_we, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have req_addr, input, 12, word address into the 4K x 16 RAM.
REQ-007 SHALL have req_wdata, input, 16, write data.
REQ-008 SHALL have req_len, input, 3, read burst length minus 1; present only when MEMCTL_BURST_EN is defined.
REQ-009 SHALL have rsp_valid, output, 1, response word available.
REQ-010 SHALL have rsp_ready, input, 1, requester consumes the response.
REQ-011 SHALL have rsp_rdata, output, 16, read data; 16'h0000 for write responses.
REQ-012 SHALL have ram_e, output, 1, RAM enable, driving RAM e.
REQ-013 SHALL have ram_w and ram_r, output, 1 each, RAM write and read strobes.
REQ-014 SHALL have ram_addr, output, 12, and ram_din, output, 16, RAM address and write data.
REQ-015 SHALL have ram_dout, input, 16, RAM combinational read data.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ and RESP; all RAM-side outputs SHALL be registered.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request SHALL be accepted on the rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL capture addr, wdata and we into ram_addr and ram_din on acceptance, then move to WRITE if we=1, else READ.
REQ-019 WRITE SHALL drive ram_e=1, ram_w=1 and ram_r=0 for exactly one cycle; the RAM commits the word on the next rising edge; the FSM then moves to RESP with rsp_rdata=0.
REQ-020 READ SHALL drive ram_e=1, ram_r=1 and ram_w=0 for exactly one cycle; ram_dout SHALL be sampled into rsp_rdata at the end of that cycle; the FSM then moves to RESP.
REQ-021 Latency SHALL be one cycle: rsp_valid rises on the second rising edge after acceptance.
REQ-022 RESP SHALL hold rsp_valid=1 and a stable rsp_rdata until rsp_ready=1, then return to IDLE on that edge.
REQ-023 ram_e, ram_w and ram_r SHALL be 0 in IDLE and RESP; ram_w and ram_r SHALL never both be 1.
REQ-024 ram_addr and ram_din SHALL hold their last values outside WRITE and READ.
REQ-025 req_valid in any non-IDLE state SHALL be ignored; the requester holds it.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, ram_e=0, ram_w=0, ram_r=0, ram_addr=0 and ram_din=0.
REQ-027 req_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-028 Reset asserted during WRITE before the commit edge SHALL abort the write, because ram_w clears asynchronously; RAM contents are not otherwise touched.

Configuration
REQ-029 With MEMCTL_BURST_EN defined, a read with req_len=N SHALL produce N+1 READ/RESP beats at consecutive addresses, wrapping 12'hFFF to 12'h000; req_ready SHALL stay 0 until the last beat is consumed.
REQ-030 With MEMCTL_BURST_EN defined, req_len SHALL be ignored for writes, so a write is always a single beat.
REQ-031 Without MEMCTL_BURST_EN, the req_len port and beat counter SHALL be absent and every transaction SHALL be a single beat.

Verification
REQ-032 Write addr 12'h123 data 16'hBEEF, then read 12'h123 -> write rsp_rdata=0 and read rsp_rdata=16'hBEEF, each rsp_valid two edges after accept.
REQ-033 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; IDLE one edge after rsp_ready=1.
REQ-034 rst_n pulsed low while in WRITE to 12'h010 with data 16'h5555 (previous content 16'h0001) -> all outputs 0 immediately; a later read of 12'h010 returns 16'h0001.
REQ-035 Monitor over random traffic -> ram_w and ram_r never both 1, and ram_e=0 whenever the state is IDLE or RESP.
REQ-036 With MEMCTL_BURST_EN, a read at addr 12'hFFE with req_len=3 -> four beats from 12'hFFE, 12'hFFF, 12'h000 and 12'h001, matching preloaded data.
